// File: rtl/regfile_write_queue.sv
// ---------------------------------------------------------------------------
// regfile_write_queue
//
// Buffered write-back front end for the 32x32 register file's single write
// port. Write-back results are queued in a small circular FIFO and drained
// one per cycle into the register file write port. Two forwarding lookups
// let decode see values that are queued (or just issued) but not yet
// committed to the register file.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   rst        synchronous active-high reset
//   wb_valid   write-back request present this cycle
//   wb_dest    destination register index of the request
//   wb_val     value of the request
//   wb_ready   queue can accept a request this cycle (count < DEPTH)
//   hold       suppresses draining for this cycle
//   src1/src2  forwarding lookup indices
//   hit1/hit2  a pending write to src1/src2 exists
//   fwd1/fwd2  youngest pending value for src1/src2 (0 on miss)
//   Write_EN   registered register file write enable
//   dest       registered register file write index
//   Write_val  registered register file write data
// ---------------------------------------------------------------------------
module regfile_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_val,
    output logic        wb_ready,
    input  logic        hold,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] fwd1,
    output logic [31:0] fwd2,
    output logic        Write_EN,
    output logic [4:0]  dest,
    output logic [31:0] Write_val
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_qDest [DEPTH];
    logic [31:0]   r_qVal  [DEPTH];
    logic [AW-1:0] r_headPtr;
    logic [AW-1:0] r_tailPtr;
    logic [CW-1:0] r_count;
    logic          r_writeEn;
    logic [4:0]    r_dest;
    logic [31:0]   r_writeVal;

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_hit1;
    logic          w_hit2;
    logic [31:0]   w_fwd1;
    logic [31:0]   w_fwd2;

    // Ready depends only on occupancy; a full queue never accepts, even if
    // it drains on the same edge. Writes to r0 complete the handshake but
    // are never stored, so they never occupy a slot.
    assign w_ready = (r_count < CW'(DEPTH));
    assign w_push  = wb_valid && w_ready && (wb_dest != 5'd0);
    assign w_pop   = (r_count != '0) && !hold;

    // Entry storage has no reset: occupancy is tracked by the pointers and
    // count, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_qDest[r_tailPtr] <= wb_dest;
            r_qVal[r_tailPtr]  <= wb_val;
        end
    end

    // Pointer, occupancy and output register update. The pop decision uses
    // the count from before this edge, so an entry pushed into an empty
    // queue waits one cycle before it can drain. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_headPtr  <= '0;
            r_tailPtr  <= '0;
            r_count    <= '0;
            r_writeEn  <= 1'b0;
            r_dest     <= 5'd0;
            r_writeVal <= 32'd0;
        end else begin
            if (w_push) begin
                r_tailPtr <= r_tailPtr + 1'b1;
            end
            if (w_pop) begin
                r_writeEn  <= 1'b1;
                r_dest     <= r_qDest[r_headPtr];
                r_writeVal <= r_qVal[r_headPtr];
                r_headPtr  <= r_headPtr + 1'b1;
            end else begin
                r_writeEn  <= 1'b0;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Forwarding lookup. The output register is the oldest candidate, so it
    // is considered first; queue entries are then scanned oldest to
    // youngest and each later match overrides, leaving the youngest value.
    // Index 0 is hard-wired to miss since r0 is never written.
    always_comb begin
        w_hit1 = 1'b0;
        w_fwd1 = 32'd0;
        w_hit2 = 1'b0;
        w_fwd2 = 32'd0;
        if (r_writeEn && (r_dest == src1)) begin
            w_hit1 = 1'b1;
            w_fwd1 = r_writeVal;
        end
        if (r_writeEn && (r_dest == src2)) begin
            w_hit2 = 1'b1;
            w_fwd2 = r_writeVal;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count) begin
                if (r_qDest[r_headPtr + AW'(i)] == src1) begin
                    w_hit1 = 1'b1;
                    w_fwd1 = r_qVal[r_headPtr + AW'(i)];
                end
                if (r_qDest[r_headPtr + AW'(i)] == src2) begin
                    w_hit2 = 1'b1;
                    w_fwd2 = r_qVal[r_headPtr + AW'(i)];
                end
            end
        end
        if (src1 == 5'd0) begin
            w_hit1 = 1'b0;
            w_fwd1 = 32'd0;
        end
        if (src2 == 5'd0) begin
            w_hit2 = 1'b0;
            w_fwd2 = 32'd0;
        end
    end

    assign wb_ready  = w_ready;
    assign hit1      = w_hit1;
    assign hit2      = w_hit2;
    assign fwd1      = w_fwd1;
    assign fwd2      = w_fwd2;
    assign Write_EN  = r_writeEn;
    assign dest      = r_dest;
    assign Write_val = r_writeVal;

endmodule

// File: tb/tb_regfile_write_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_queue
//
// Self-checking bench for regfile_write_queue. A queue-based behavioural
// model tracks pending writes and the register file port; one compare
// process checks every output against it each cycle, and directed
// sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_val;
    logic        wb_ready;
    logic        hold;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic        Write_EN;
    logic [4:0]  dest;
    logic [31:0] Write_val;

    int nVectors;
    int nMiscompares;
    bit checkOn;

    typedef struct packed {
        logic [4:0]  d;
        logic [31:0] v;
    } entryT;

    entryT       mQueue[$];
    logic        mWe;
    logic [4:0]  mDest;
    logic [31:0] mVal;

    regfile_write_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_dest   (wb_dest),
        .wb_val    (wb_val),
        .wb_ready  (wb_ready),
        .hold      (hold),
        .src1      (src1),
        .src2      (src2),
        .hit1      (hit1),
        .hit2      (hit2),
        .fwd1      (fwd1),
        .fwd2      (fwd2),
        .Write_EN  (Write_EN),
        .dest      (dest),
        .Write_val (Write_val)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one value and records the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs just after a negedge; returns 2 time units
    // later so callers can make literal checks on the settled outputs.
    task automatic applyStimulus(input logic r, input logic v, input logic [4:0] d,
                                 input logic [31:0] val, input logic h,
                                 input logic [4:0] s1, input logic [4:0] s2);
        @(negedge clk);
        rst      = r;
        wb_valid = v;
        wb_dest  = d;
        wb_val   = val;
        hold     = h;
        src1     = s1;
        src2     = s2;
        #2;
    endtask

    // Youngest-first search over pending writes: queued entries newest to
    // oldest, then the write currently presented to the register file.
    function automatic void modelLookup(input logic [4:0] s, output logic h,
                                        output logic [31:0] f);
        h = 1'b0;
        f = 32'd0;
        if (s != 5'd0) begin
            for (int k = mQueue.size() - 1; k >= 0; k--) begin
                if (!h && mQueue[k].d == s) begin
                    h = 1'b1;
                    f = mQueue[k].v;
                end
            end
            if (!h && mWe && mDest == s) begin
                h = 1'b1;
                f = mVal;
            end
        end
    endfunction

    // Behavioural model: occupancy is the queue length; a drain uses the
    // queue as it stood before this edge, then any accepted request joins.
    initial begin
        bit    ready;
        entryT e;
        mWe   = 1'b0;
        mDest = 5'd0;
        mVal  = 32'd0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mQueue.delete();
                mWe   = 1'b0;
                mDest = 5'd0;
                mVal  = 32'd0;
            end else begin
                ready = (mQueue.size() < DEPTH);
                if (mQueue.size() > 0 && !hold) begin
                    e     = mQueue.pop_front();
                    mWe   = 1'b1;
                    mDest = e.d;
                    mVal  = e.v;
                end else begin
                    mWe = 1'b0;
                end
                if (wb_valid && ready && wb_dest != 5'd0) begin
                    mQueue.push_back('{d: wb_dest, v: wb_val});
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, sampled
    // mid-cycle once inputs for the cycle have been applied.
    initial begin
        logic        eh1;
        logic        eh2;
        logic [31:0] ef1;
        logic [31:0] ef2;
        forever begin
            @(negedge clk);
            #1;
            if (checkOn) begin
                modelLookup(src1, eh1, ef1);
                modelLookup(src2, eh2, ef2);
                checkOutput("wb_ready", {31'd0, wb_ready}, {31'd0, mQueue.size() < DEPTH});
                checkOutput("Write_EN", {31'd0, Write_EN}, {31'd0, mWe});
                checkOutput("dest", {27'd0, dest}, {27'd0, mDest});
                checkOutput("Write_val", Write_val, mVal);
                checkOutput("hit1", {31'd0, hit1}, {31'd0, eh1});
                checkOutput("hit2", {31'd0, hit2}, {31'd0, eh2});
                checkOutput("fwd1", fwd1, ef1);
                checkOutput("fwd2", fwd2, ef2);
            end
        end
    end

    // Directed sequences with hand-computed expectations.
    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        checkOn      = 1'b0;
        rst          = 1'b1;
        wb_valid     = 1'b0;
        wb_dest      = 5'd0;
        wb_val       = 32'd0;
        hold         = 1'b0;
        src1         = 5'd0;
        src2         = 5'd0;

        // Reset, then check reset values.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        checkOutput("rst_ready", {31'd0, wb_ready}, 32'd1);
        checkOutput("rst_we", {31'd0, Write_EN}, 32'd0);
        checkOutput("rst_dest", {27'd0, dest}, 32'd0);
        checkOutput("rst_val", Write_val, 32'd0);
        checkOutput("rst_hit1", {31'd0, hit1}, 32'd0);

        // Single write: visible to forwarding once queued, issued one cycle later.
        applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 5, 0);
        checkOutput("t1_incoming_not_hit", {31'd0, hit1}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        checkOutput("t1_q_hit1", {31'd0, hit1}, 32'd1);
        checkOutput("t1_q_fwd1", fwd1, 32'hDEADBEEF);
        checkOutput("t1_q_we", {31'd0, Write_EN}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        checkOutput("t1_we", {31'd0, Write_EN}, 32'd1);
        checkOutput("t1_dest", {27'd0, dest}, 32'd5);
        checkOutput("t1_val", Write_val, 32'hDEADBEEF);
        checkOutput("t1_out_fwd1", fwd1, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        checkOutput("t1_we_off", {31'd0, Write_EN}, 32'd0);
        checkOutput("t1_dest_hold", {27'd0, dest}, 32'd5);
        checkOutput("t1_hit_gone", {31'd0, hit1}, 32'd0);

        // Fill under hold: four accepted, then backpressure.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 1, 5'(i), 32'(i * 256), 1, 0, 0);
            checkOutput("t2_ready", {31'd0, wb_ready}, (i <= 4) ? 32'd1 : 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 3, 0);
        checkOutput("t2_held_we", {31'd0, Write_EN}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 3, 0);
            checkOutput("t2_we", {31'd0, Write_EN}, 32'd1);
            checkOutput("t2_dest", {27'd0, dest}, 32'(k));
            checkOutput("t2_val", Write_val, 32'(k * 256));
        end
        applyStimulus(0, 1, 5, 32'h500, 0, 0, 0);
        checkOutput("t2_drained_we", {31'd0, Write_EN}, 32'd0);
        applyStimulus(0, 1, 6, 32'h600, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_dest5", {27'd0, dest}, 32'd5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_dest6", {27'd0, dest}, 32'd6);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Youngest-wins forwarding.
        applyStimulus(0, 1, 7, 32'h11, 1, 0, 0);
        applyStimulus(0, 1, 7, 32'h22, 1, 0, 0);
        applyStimulus(0, 1, 8, 32'h33, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 7, 8);
        checkOutput("t3_hit1", {31'd0, hit1}, 32'd1);
        checkOutput("t3_fwd1", fwd1, 32'h22);
        checkOutput("t3_hit2", {31'd0, hit2}, 32'd1);
        checkOutput("t3_fwd2", fwd2, 32'h33);
        applyStimulus(0, 0, 0, 0, 1, 0, 8);
        checkOutput("t3_src0_hit", {31'd0, hit1}, 32'd0);
        checkOutput("t3_src0_fwd", fwd1, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 7, 8);
        applyStimulus(0, 0, 0, 0, 0, 7, 8);
        checkOutput("t3_drain_val", Write_val, 32'h11);
        checkOutput("t3_drain_fwd1", fwd1, 32'h22);
        applyStimulus(0, 0, 0, 0, 0, 7, 8);
        checkOutput("t3_out_fwd1", fwd1, 32'h22);
        applyStimulus(0, 0, 0, 0, 0, 7, 8);
        checkOutput("t3_dest8", {27'd0, dest}, 32'd8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Writes to r0 are accepted and dropped.
        applyStimulus(0, 1, 0, 32'hFFFF, 0, 0, 0);
        checkOutput("t4_ready0", {31'd0, wb_ready}, 32'd1);
        applyStimulus(0, 1, 3, 32'h1, 0, 3, 0);
        checkOutput("t4_no_r0_write", {31'd0, Write_EN}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 3, 0);
        checkOutput("t4_still_none", {31'd0, Write_EN}, 32'd0);
        checkOutput("t4_hit3", {31'd0, hit1}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 3, 0);
        checkOutput("t4_dest3", {27'd0, dest}, 32'd3);
        checkOutput("t4_val1", Write_val, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_single", {31'd0, Write_EN}, 32'd0);

        // Back-to-back stream, pointers wrap twice.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 5'(i + 1), 32'(i), 0, 5'(i + 1), 5'(i));
            checkOutput("t5_ready", {31'd0, wb_ready}, 32'd1);
            if (i >= 2) begin
                checkOutput("t5_we", {31'd0, Write_EN}, 32'd1);
                checkOutput("t5_dest", {27'd0, dest}, 32'(i - 1));
                checkOutput("t5_val", Write_val, 32'(i - 2));
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_dest9", {27'd0, dest}, 32'd9);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_dest10", {27'd0, dest}, 32'd10);
        checkOutput("t5_val9", Write_val, 32'd9);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a drain discards everything.
        applyStimulus(0, 1, 20, 32'hA, 1, 0, 0);
        applyStimulus(0, 1, 21, 32'hB, 1, 0, 0);
        applyStimulus(0, 1, 22, 32'hC, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 21, 22);
        applyStimulus(0, 0, 0, 0, 0, 21, 22);
        checkOutput("t6_draining", {27'd0, dest}, 32'd20);
        applyStimulus(1, 1, 23, 32'hD, 0, 21, 22);
        applyStimulus(0, 0, 0, 0, 0, 21, 22);
        checkOutput("t6_we", {31'd0, Write_EN}, 32'd0);
        checkOutput("t6_dest", {27'd0, dest}, 32'd0);
        checkOutput("t6_val", Write_val, 32'd0);
        checkOutput("t6_hit1", {31'd0, hit1}, 32'd0);
        checkOutput("t6_hit2", {31'd0, hit2}, 32'd0);
        checkOutput("t6_ready", {31'd0, wb_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 23, 21);
            checkOutput("t6_no_stale", {31'd0, Write_EN}, 32'd0);
        end

        checkOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffered write-back front end for the 32×32 register file's single write port. Accepts write-back results (dest, value) from the pipeline, queues them in a small FIFO, and drains one per cycle into the register file's write port (Write_EN / dest / Write_val). Also answers forwarding lookups on two source indices, so decode can see values that are queued but not yet written. It sits between the WB stage and the register file; its outputs connect directly to the register file write inputs.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2.
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- wb_valid  input  1  write-back request present this cycle.
- wb_dest  input  5  destination register index.
- wb_val  input  32  value to write.
- wb_ready  output  1  queue can accept a request this cycle.
- hold  input  1  when high, no entry is drained this cycle.
- src1  input  5  forwarding lookup index 1.
- src2  input  5  forwarding lookup index 2.
- hit1  output  1  a pending write to src1 exists.
- hit2  output  1  a pending write to src2 exists.
- fwd1  output  32  youngest pending value for src1; valid when hit1 is high.
- fwd2  output  32  youngest pending value for src2; valid when hit2 is high.
- Write_EN  output  1  register file write enable (registered).
- dest  output  5  register file write index (registered).
- Write_val  output  32  register file write data (registered).

## Operation
- Storage is a circular FIFO of DEPTH entries {dest, val}, with head pointer, tail pointer and count (width log2(DEPTH)+1).
- **Enqueue.** A request is accepted on a posedge where wb_valid && wb_ready. It is written at tail; tail wraps modulo DEPTH.
- **Dest 0.** A request with wb_dest==0 is accepted (handshake completes) but discarded. Nothing is stored, count is unchanged.
- **wb_ready.** wb_ready = (count < DEPTH). It depends only on count, with no pass-through when full.
- **Drain.** On each posedge with count>0 and !hold:
  - The head entry is popped.
  - Write_EN<=1, dest<=head.dest, Write_val<=head.val.
  - Head wraps modulo DEPTH.
- **Idle drain.** On any posedge with no drain: Write_EN<=0. dest and Write_val hold their previous values.
- **Simultaneous enqueue and drain.** Count is unchanged. This is legal at any count 1..DEPTH-1.
  - At count==0, the entry enqueued this edge is not drained this edge; it becomes eligible next cycle.
- **Forwarding (combinational).** For each srcN, candidates are the valid queue entries plus the output register when Write_EN==1.
  - Priority is youngest first: queue entries from tail-1 back to head, then the output register.
  - The first candidate with matching dest gives hitN=1 and fwdN=its value. Otherwise hitN=0 and fwdN=0.
  - srcN==0 always gives hitN=0, fwdN=0.
  - The incoming wb_* request of the current cycle is not a candidate.
- **Ordering.** Writes reach the register file in acceptance order. No coalescing.
- **Reset (rst high at posedge).**
  - count=0, head=tail=0.
  - Write_EN=0, dest=0, Write_val=0.
  - Queue contents are dropped, including entries mid-drain. No write is issued on the reset edge.
  - wb_valid and hold are ignored while rst is high.

## Timing
- Reset values: wb_ready=1, hit1=hit2=0, fwd1=fwd2=0, Write_EN=0, dest=0, Write_val=0.
- Latency: a request accepted at posedge N into an empty queue with hold low appears on Write_EN/dest/Write_val after posedge N+1. The register file commits it on the following negedge.
- Throughput: one accept and one drain per cycle, sustained.
- hit/fwd are purely combinational from src1/src2 and current state; they change the same cycle the state changes.
- Write_EN is a single-cycle pulse per drained entry. It is high on consecutive cycles when draining back-to-back.
- hold asserted: the queue still accepts until full. Outputs show Write_EN=0 from the next edge.

## Test plan
- **Reset then single write.** rst 1 cycle; wb_valid=1, dest=5, val=0xDEADBEEF for one cycle -> Write_EN=1, dest=5, Write_val=0xDEADBEEF exactly one cycle later, then Write_EN=0. Meanwhile hit1=1, fwd1=0xDEADBEEF while src1=5 and the entry is pending or in the output register.
- **Fill and backpressure.** hold=1; offer 6 requests dest=1..6 -> first 4 accepted, wb_ready=0 after the 4th. Release hold -> writes to 1,2,3,4 on 4 consecutive cycles. Re-offering dest=5,6 then completes in order.
- **Youngest-wins forwarding.** hold=1; enqueue (7,0x11), (7,0x22), (8,0x33); src1=7, src2=8 -> fwd1=0x22, fwd2=0x33, both hits=1. src1=0 -> hit1=0.
- **Dest 0 discard.** Enqueue (0,0xFFFF) then (3,0x1) -> only dest=3 is written; count never exceeds 1.
- **Simultaneous enqueue/drain with pointer wrap.** Stream 10 back-to-back requests (dest=i+1, val=i) with hold=0 -> wb_ready stays 1 and 10 in-order writes occur, each 1 cycle after acceptance, with pointers wrapping twice.
- **Reset mid-operation.** Queue holds 3 entries, drain in progress; assert rst -> next cycle Write_EN=0, count=0, hits=0. No stale entry is ever written after reset.
